// File: rtl/pc_sequencer.sv
// Program-counter sequencer: start/stall/jump/call/return/halt control with a return-address stack.
// Define PC_SEQ_REL_JUMP_EN to make jump_req PC-relative (call/ret stay absolute).
module pc_sequencer #(
    parameter int D         = 10,
    parameter int RAS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         jump_req,
    input  logic         call_req,
    input  logic         ret_req,
    input  logic         halt_req,
    input  logic [D-1:0] jump_tgt,
    input  logic [D-1:0] prog_ctr,
    output logic         pc_reset,
    output logic         absjump_en,
    output logic [D-1:0] target,
    output logic         running,
    output logic         done,
    output logic         ras_err
);

    localparam int SPW = $clog2(RAS_DEPTH + 1);
    localparam int IW  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_next;
    logic           ras_err_next;
    logic           push_en;
    logic [D-1:0]   ras [RAS_DEPTH];
    logic [D-1:0]   ret_addr;
    logic [D-1:0]   jump_dest;
    logic [IW-1:0]  push_idx;
    logic [IW-1:0]  top_idx;

    assign ret_addr = prog_ctr + D'(1);
    assign push_idx = IW'(sp);
    assign top_idx  = IW'(sp - SPW'(1));

`ifdef PC_SEQ_REL_JUMP_EN
    assign jump_dest = prog_ctr + jump_tgt;
`else
    assign jump_dest = jump_tgt;
`endif

    // Holding the PC means jumping to its own address, since it increments otherwise.
    always_comb begin
        state_next   = state;
        sp_next      = sp;
        ras_err_next = ras_err;
        push_en      = 1'b0;
        pc_reset     = 1'b0;
        absjump_en   = 1'b0;
        target       = '0;
        running      = 1'b0;
        done         = 1'b0;

        case (state)
            IDLE: begin
                pc_reset = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                running = 1'b1;
                if (halt_req) begin
                    absjump_en = 1'b1;
                    target     = prog_ctr;
                    state_next = HALT;
                end else if (stall) begin
                    absjump_en = 1'b1;
                    target     = prog_ctr;
                end else if (ret_req) begin
                    absjump_en = 1'b1;
                    if (sp != '0) begin
                        target  = ras[top_idx];
                        sp_next = sp - SPW'(1);
                    end else begin
                        target       = prog_ctr;
                        ras_err_next = 1'b1;
                    end
                end else if (call_req) begin
                    absjump_en = 1'b1;
                    target     = jump_tgt;
                    if (sp != SP_FULL) begin
                        push_en = 1'b1;
                        sp_next = sp + SPW'(1);
                    end else begin
                        ras_err_next = 1'b1;
                    end
                end else if (jump_req) begin
                    absjump_en = 1'b1;
                    target     = jump_dest;
                end
            end
            HALT: begin
                done       = 1'b1;
                absjump_en = 1'b1;
                target     = prog_ctr;
                if (start) begin
                    state_next   = IDLE;
                    sp_next      = '0;
                    ras_err_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Reset overrides the PC drive in the same cycle so the PC clears on the next edge.
        if (reset) begin
            pc_reset   = 1'b1;
            absjump_en = 1'b0;
            target     = '0;
            running    = 1'b0;
            done       = 1'b0;
            push_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            sp      <= '0;
            ras_err <= 1'b0;
        end else begin
            state   <= state_next;
            sp      <= sp_next;
            ras_err <= ras_err_next;
        end
    end

    // Stack storage needs no reset; entries are only read below the pointer.
    always_ff @(posedge clk) begin
        if (push_en) ras[push_idx] <= ret_addr;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural PC register and an expected-value queue.
// Expected jump targets follow the PC_SEQ_REL_JUMP_EN setting of the build.
module tb_pc_sequencer;

    localparam int D = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         stall;
    logic         jump_req;
    logic         call_req;
    logic         ret_req;
    logic         halt_req;
    logic [D-1:0] jump_tgt;
    logic [D-1:0] pc = '0;
    logic         pc_reset;
    logic         absjump_en;
    logic [D-1:0] target;
    logic         running;
    logic         done;
    logic         ras_err;

    typedef struct {
        string        tag;
        logic         pcr;
        logic         abs;
        logic [D-1:0] tgt;
        logic         run;
        logic         dn;
        logic         err;
        logic [D-1:0] pcv;
    } exp_t;

    exp_t expq[$];
    int   testCount = 0;
    int   failCount = 0;

    logic [D-1:0] jpc;
    logic [D-1:0] hpc;

    pc_sequencer #(.D(D), .RAS_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall),
        .jump_req(jump_req), .call_req(call_req), .ret_req(ret_req), .halt_req(halt_req),
        .jump_tgt(jump_tgt), .prog_ctr(pc), .pc_reset(pc_reset), .absjump_en(absjump_en),
        .target(target), .running(running), .done(done), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // The PC the sequencer controls: clear, absolute load, or increment.
    always_ff @(posedge clk) begin
        if (pc_reset)        pc <= '0;
        else if (absjump_en) pc <= target;
        else                 pc <= pc + D'(1);
    end

    task automatic cmp(input string tag, input string field, input logic [D-1:0] obs, input logic [D-1:0] expv);
        testCount++;
        assert (obs === expv) else begin
            failCount++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expq.size() == 0) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
        end else begin
            e = expq.pop_front();
            cmp(e.tag, "pc_reset",   D'(pc_reset),   D'(e.pcr));
            cmp(e.tag, "absjump_en", D'(absjump_en), D'(e.abs));
            cmp(e.tag, "target",     target,         e.tgt);
            cmp(e.tag, "running",    D'(running),    D'(e.run));
            cmp(e.tag, "done",       D'(done),       D'(e.dn));
            cmp(e.tag, "ras_err",    D'(ras_err),    D'(e.err));
            cmp(e.tag, "pc",         pc,             e.pcv);
        end
    endtask

    task automatic applyStimulus(
        input string tag,
        input logic r, input logic st, input logic sl, input logic jr,
        input logic cr, input logic rr, input logic hr, input logic [D-1:0] tgt,
        input logic epcr, input logic eabs, input logic [D-1:0] etgt,
        input logic erun, input logic edone, input logic eerr, input logic [D-1:0] epc);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; start = st; stall = sl; jump_req = jr;
        call_req = cr; ret_req = rr; halt_req = hr; jump_tgt = tgt;
        e.tag = tag; e.pcr = epcr; e.abs = eabs; e.tgt = etgt;
        e.run = erun; e.dn = edone; e.err = eerr; e.pcv = epc;
        expq.push_back(e);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; jump_req = 1'b0;
        call_req = 1'b0; ret_req = 1'b0; halt_req = 1'b0; jump_tgt = '0;
`ifdef PC_SEQ_REL_JUMP_EN
        jpc = 10'd8;
`else
        jpc = 10'h3FE;
`endif
        hpc = jpc + 10'd3;

        //            tag         r  st sl jr cr rr hr tgt     pcr abs tgt     run dn err pc
        applyStimulus("reset0",   1, 0, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("reset1",   1, 0, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("idle_jmp", 0, 0, 0, 1, 0, 0, 0, 10'h55, 1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("start",    0, 1, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("inc0",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h0);
        applyStimulus("inc1",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h1);
        applyStimulus("inc2",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h2);
        applyStimulus("stall0",   0, 0, 1, 0, 0, 0, 0, 10'h0,  0, 1, 10'h3,   1, 0, 0, 10'h3);
        applyStimulus("stall1",   0, 0, 1, 0, 0, 0, 0, 10'h0,  0, 1, 10'h3,   1, 0, 0, 10'h3);
        applyStimulus("stall2",   0, 0, 1, 0, 0, 0, 0, 10'h0,  0, 1, 10'h3,   1, 0, 0, 10'h3);
        applyStimulus("unstall",  0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h3);
        applyStimulus("inc4",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h4);
        applyStimulus("call",     0, 0, 0, 0, 1, 0, 0, 10'h100, 0, 1, 10'h100, 1, 0, 0, 10'h5);
        applyStimulus("sub0",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h100);
        applyStimulus("sub1",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h101);
        applyStimulus("ret",      0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h6,   1, 0, 0, 10'h102);
        applyStimulus("after_ret",0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h6);
        applyStimulus("ncall1",   0, 0, 0, 0, 1, 0, 0, 10'h10, 0, 1, 10'h10,  1, 0, 0, 10'h7);
        applyStimulus("ncall2",   0, 0, 0, 0, 1, 0, 0, 10'h20, 0, 1, 10'h20,  1, 0, 0, 10'h10);
        applyStimulus("ncall3",   0, 0, 0, 0, 1, 0, 0, 10'h30, 0, 1, 10'h30,  1, 0, 0, 10'h20);
        applyStimulus("ncall4",   0, 0, 0, 0, 1, 0, 0, 10'h40, 0, 1, 10'h40,  1, 0, 0, 10'h30);
        applyStimulus("ncall5",   0, 0, 0, 0, 1, 0, 0, 10'h50, 0, 1, 10'h50,  1, 0, 0, 10'h40);
        applyStimulus("nret1",    0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h31,  1, 0, 1, 10'h50);
        applyStimulus("nret2",    0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h21,  1, 0, 1, 10'h31);
        applyStimulus("nret3",    0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h11,  1, 0, 1, 10'h21);
        applyStimulus("nret4",    0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h8,   1, 0, 1, 10'h11);
        applyStimulus("nret5",    0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h8,   1, 0, 1, 10'h8);
        applyStimulus("uflow_inc",0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 1, 10'h8);
        applyStimulus("pcall",    0, 0, 0, 0, 1, 0, 0, 10'h200, 0, 1, 10'h200, 1, 0, 1, 10'h9);
        applyStimulus("call_ret", 0, 0, 0, 0, 1, 1, 0, 10'h300, 0, 1, 10'hA,  1, 0, 1, 10'h200);
        applyStimulus("jump",     0, 0, 0, 1, 0, 0, 0, 10'h3FE, 0, 1, jpc,    1, 0, 1, 10'hA);
        applyStimulus("post_j0",  0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 1, jpc);
        applyStimulus("post_j1",  0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 1, jpc + 10'd1);
        applyStimulus("post_j2",  0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 1, jpc + 10'd2);
        applyStimulus("halt",     0, 0, 1, 1, 0, 0, 1, 10'h123, 0, 1, hpc,    1, 0, 1, hpc);
        applyStimulus("halted",   0, 0, 0, 1, 0, 0, 0, 10'h77, 0, 1, hpc,     0, 1, 1, hpc);
        applyStimulus("rearm",    0, 1, 0, 0, 0, 0, 0, 10'h0,  0, 1, hpc,     0, 1, 1, hpc);
        applyStimulus("idle2",    0, 0, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, hpc);
        applyStimulus("start2",   0, 1, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("run2",     0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 0, 10'h0);
        applyStimulus("stall_r",  0, 0, 1, 0, 0, 0, 0, 10'h0,  0, 1, 10'h1,   1, 0, 0, 10'h1);
        applyStimulus("rst_stall",1, 0, 1, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h1);
        applyStimulus("idle3",    0, 0, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("start3",   0, 1, 0, 0, 0, 0, 0, 10'h0,  1, 0, 10'h0,   0, 0, 0, 10'h0);
        applyStimulus("ret_empty",0, 0, 0, 0, 0, 1, 0, 10'h0,  0, 1, 10'h0,   1, 0, 0, 10'h0);
        applyStimulus("err_set",  0, 0, 0, 0, 0, 0, 0, 10'h0,  0, 0, 10'h0,   1, 0, 1, 10'h0);

        if (expq.size() != 0) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
